// File: rtl/arbiter_rr_burst_pkg.sv
// Shared types and the round-robin search used by the burst arbiter.
// rr_next scans from the requester just after lowest_prio and wraps modulo n.
package arbiter_pkg;

  typedef enum logic {ARB_IDLE, ARB_LOCKED} arb_state_t;

  localparam int RR_MAX_N = 32;
  localparam int RR_IDX_W = 5;

  typedef struct packed {
    logic                found;
    logic [RR_IDX_W-1:0] idx;
  } rr_result_t;

  function automatic rr_result_t rr_next(input logic [RR_MAX_N-1:0] req,
                                         input int n,
                                         input int lowest_prio);
    rr_result_t res;
    int         idx;
    res = '0;
    for (int k = 1; k <= RR_MAX_N; k++) begin
      idx = lowest_prio + k;
      if (idx >= n) idx = idx - n;
      if (k <= n && !res.found && req[idx[RR_IDX_W-1:0]]) begin
        res.found = 1'b1;
        res.idx   = idx[RR_IDX_W-1:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/arbiter_rr_burst_sel.sv
// Combinational round-robin selector: first requester after lowest_prio, wrapping.
module rr_priority_select
  import arbiter_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] lowest_prio_i,
  output logic [IDX_W-1:0] grant_idx_o,
  output logic             grant_found_o
);

  rr_result_t res;

  always_comb begin
    res           = rr_next(RR_MAX_N'(req_i), N, int'(lowest_prio_i));
    grant_found_o = res.found;
    grant_idx_o   = IDX_W'(res.idx);
  end

endmodule

// File: rtl/arbiter_rr_burst.sv
// N-to-1 round-robin arbiter that locks onto a winner until its last beat,
// feeding a single registered output stage with one beat per cycle throughput.
module arbiter_rr_burst
  import arbiter_pkg::*;
#(
  parameter int DWIDTH           = 16,
  parameter int N                = 2,
  parameter int INIT_LOWEST_PRIO = N - 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic [N-1:0]                  in_valid,
  input  logic [N-1:0][DWIDTH-1:0]      in_data,
  input  logic [N-1:0]                  in_last,
  output logic [N-1:0]                  in_ready,
  output logic                          out_valid,
  output logic [DWIDTH-1:0]             out_data,
  output logic                          out_last,
  output logic [$clog2(N)-1:0]          out_src,
  input  logic                          out_ready,
  output logic                          locked
);

  localparam int IDX_W = $clog2(N);

  arb_state_t              state_q, state_d;
  logic [IDX_W-1:0]        lowest_q, lowest_d;
  logic [IDX_W-1:0]        lock_idx_q, lock_idx_d;
  logic                    out_valid_q, out_valid_d;
  logic [DWIDTH-1:0]       out_data_q, out_data_d;
  logic                    out_last_q, out_last_d;
  logic [IDX_W-1:0]        out_src_q, out_src_d;

  logic                    slot_free;
  logic [IDX_W-1:0]        grant_idx;
  logic                    grant_found;
  logic [IDX_W-1:0]        sel_idx;
  logic                    accept;
  logic                    acc_last;

  rr_priority_select #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_sel (
    .req_i         (in_valid),
    .lowest_prio_i (lowest_q),
    .grant_idx_o   (grant_idx),
    .grant_found_o (grant_found)
  );

  always_comb begin
    slot_free = !out_valid_q || out_ready;
    sel_idx   = (state_q == ARB_LOCKED) ? lock_idx_q : grant_idx;
    in_ready  = '0;
    // While locked the owner is granted even through bubbles, so others stay blocked.
    if (rst_n && slot_free && (state_q == ARB_LOCKED || grant_found))
      in_ready[sel_idx] = 1'b1;
    accept   = |(in_valid & in_ready);
    acc_last = in_last[sel_idx];

    state_d    = state_q;
    lowest_d   = lowest_q;
    lock_idx_d = lock_idx_q;
    case (state_q)
      ARB_IDLE: begin
        if (accept) begin
          if (acc_last) begin
            lowest_d = sel_idx;
          end else begin
            lock_idx_d = sel_idx;
            state_d    = ARB_LOCKED;
          end
        end
      end
      ARB_LOCKED: begin
        if (accept && acc_last) begin
          lowest_d = lock_idx_q;
          state_d  = ARB_IDLE;
        end
      end
      default: state_d = ARB_IDLE;
    endcase

    out_valid_d = accept ? 1'b1 : (out_ready ? 1'b0 : out_valid_q);
    out_data_d  = accept ? in_data[sel_idx] : out_data_q;
    out_last_d  = accept ? acc_last : out_last_q;
    out_src_d   = accept ? sel_idx : out_src_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ARB_IDLE;
      lowest_q    <= IDX_W'(INIT_LOWEST_PRIO);
      lock_idx_q  <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      lowest_q    <= lowest_d;
      lock_idx_q  <= lock_idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;
  assign locked    = (state_q == ARB_LOCKED);

endmodule

// File: tb/tb_arbiter_rr_burst.sv
// Scoreboard bench for arbiter_rr_burst with four requesters: directed scenarios
// followed by a long random run with order, interleave and starvation checks.
module tb_arbiter_rr_burst;

  localparam int N  = 4;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [N-1:0]         in_valid;
  logic [N-1:0][DW-1:0] in_data;
  logic [N-1:0]         in_last;
  logic [N-1:0]         in_ready;
  logic                 out_valid;
  logic [DW-1:0]        out_data;
  logic                 out_last;
  logic [1:0]           out_src;
  logic                 out_ready;
  logic                 locked;

  arbiter_rr_burst #(.DWIDTH(DW), .N(N)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_last  (out_last),
    .out_src   (out_src),
    .out_ready (out_ready),
    .locked    (locked)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] d;
    logic          l;
    logic [1:0]    s;
  } sb_t;

  sb_t sb_q[$];

  int n_checks = 0;
  int n_errors = 0;

  // reference model state
  bit  m_locked = 0;
  int  m_lowest = N - 1;
  int  m_lock   = 0;
  bit  m_ov     = 0;

  logic [13:0] seq     [N];
  logic [13:0] out_seq [N];
  int          wait_cnt[N];
  bit          chk_starve = 0;
  bit          verbose    = 1;
  bit          ob_active  = 0;
  logic [1:0]  ob_src     = '0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [N-1:0] model_ready(input logic [N-1:0] v, input bit ordy);
    logic [N-1:0] r;
    r = '0;
    if (!m_ov || ordy) begin
      if (m_locked) begin
        r[m_lock] = 1'b1;
      end else begin
        for (int k = 1; k <= N; k++) begin
          if (r == '0 && v[(m_lowest + k) % N]) r[(m_lowest + k) % N] = 1'b1;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    m_locked  = 0;
    m_lowest  = N - 1;
    m_ov      = 0;
    ob_active = 0;
    sb_q.delete();
    for (int i = 0; i < N; i++) out_seq[i] = seq[i];
  endtask

  // One clock cycle; called just after a falling edge, returns just after the next one.
  task automatic cycle(input logic [N-1:0] v, input logic [N-1:0] l, input bit ordy,
                       output logic [N-1:0] dacc);
    logic [N-1:0] er, macc;
    sb_t          e;
    int           j;
    in_valid  = v;
    in_last   = l;
    out_ready = ordy;
    for (int i = 0; i < N; i++) in_data[i] = {2'(i), seq[i]};
    #1;
    er = model_ready(v, ordy);
    check("in_ready", 32'(in_ready), 32'(er));
    check("out_valid", 32'(out_valid), 32'(m_ov));
    check("locked", 32'(locked), 32'(m_locked));
    if (m_ov && ordy) begin
      if (sb_q.size() == 0) begin
        check("sb_underflow", 32'(1), 32'(0));
      end else begin
        e = sb_q.pop_front();
        check("out_data", 32'(out_data), 32'(e.d));
        check("out_last", 32'(out_last), 32'(e.l));
        check("out_src", 32'(out_src), 32'(e.s));
        check("src_order", 32'(out_data[13:0]), 32'(out_seq[e.s]));
        out_seq[e.s] = out_seq[e.s] + 14'd1;
        if (ob_active) check("interleave", 32'(out_src), 32'(ob_src));
        ob_active = !out_last;
        ob_src    = out_src;
        if (verbose)
          $display("beat src=%0d data=%h last=%0b", out_src, out_data, out_last);
      end
    end
    dacc = in_ready & v;
    macc = er & v;
    @(posedge clk);
    for (int i = 0; i < N; i++) if (dacc[i]) seq[i] = seq[i] + 14'd1;
    if (macc != '0) begin
      j = 0;
      for (int i = 0; i < N; i++) if (macc[i]) j = i;
      if (l[j]) for (int i = 0; i < N; i++) if (i != j && v[i]) wait_cnt[i]++;
      if (chk_starve) check("starve", 32'(wait_cnt[j] <= N), 32'(1));
      wait_cnt[j] = 0;
      e.d = in_data[j];
      e.l = l[j];
      e.s = 2'(j);
      sb_q.push_back(e);
      if (!m_locked) begin
        if (l[j]) m_lowest = j;
        else begin
          m_locked = 1;
          m_lock   = j;
        end
      end else if (l[j]) begin
        m_locked = 0;
        m_lowest = m_lock;
      end
      m_ov = 1;
    end else if (ordy) begin
      m_ov = 0;
    end
    @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [N-1:0] dacc;
    logic [N-1:0] rv, rl;
    logic [N-1:0] t1_exp [5];
    logic [DW-1:0] held;
    int            lk;

    t1_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
    for (int i = 0; i < N; i++) begin
      seq[i]      = '0;
      out_seq[i]  = '0;
      wait_cnt[i] = 0;
    end
    rst_n     = 1'b0;
    in_valid  = '1;
    in_last   = '1;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 32'(0));
    check("rst_out_data", 32'(out_data), 32'(0));
    check("rst_out_last", 32'(out_last), 32'(0));
    check("rst_out_src", 32'(out_src), 32'(0));
    check("rst_locked", 32'(locked), 32'(0));
    check("rst_in_ready", 32'(in_ready), 32'(0));
    rst_n    = 1'b1;
    in_valid = '0;

    // 1: all requesting single beats -> strict rotation
    for (int k = 0; k < 5; k++) begin
      cycle(4'b1111, 4'b1111, 1'b1, dacc);
      check("t1_grant", 32'(dacc), 32'(t1_exp[k]));
    end
    repeat (2) cycle(4'b0000, 4'b0000, 1'b1, dacc);

    // 2: req1 three-beat burst while req0 waits
    lk = 0;
    cycle(4'b0011, 4'b0001, 1'b1, dacc); lk += int'(locked);
    cycle(4'b0011, 4'b0001, 1'b1, dacc); lk += int'(locked);
    cycle(4'b0011, 4'b0011, 1'b1, dacc); lk += int'(locked);
    check("t2_grant_last", 32'(dacc), 32'(4'b0010));
    cycle(4'b0001, 4'b0001, 1'b1, dacc); lk += int'(locked);
    check("t2_locked_cycles", 32'(lk), 32'(2));
    check("t2_grant_req0", 32'(dacc), 32'(4'b0001));
    repeat (2) cycle(4'b0000, 4'b0000, 1'b1, dacc);

    // 3: lock on req2 with a two-cycle bubble
    cycle(4'b0100, 4'b0000, 1'b1, dacc);
    check("t3_lock", 32'(locked), 32'(1));
    repeat (2) begin
      cycle(4'b0011, 4'b0011, 1'b1, dacc);
      check("t3_bubble_block", 32'(dacc), 32'(0));
    end
    cycle(4'b0111, 4'b0111, 1'b1, dacc);
    check("t3_resume", 32'(dacc), 32'(4'b0100));
    repeat (2) cycle(4'b0000, 4'b0000, 1'b1, dacc);

    // 4: output stall holds data, release reloads the same cycle
    cycle(4'b0001, 4'b0001, 1'b1, dacc);
    held = out_data;
    repeat (3) begin
      cycle(4'b0010, 4'b0010, 1'b0, dacc);
      check("t4_stall_data", 32'(out_data), 32'(held));
    end
    cycle(4'b0010, 4'b0010, 1'b1, dacc);
    check("t4_release_load", 32'(dacc), 32'(4'b0010));
    repeat (2) cycle(4'b0000, 4'b0000, 1'b1, dacc);

    // 5: asynchronous reset during beat 2 of a burst
    cycle(4'b1000, 4'b0000, 1'b1, dacc);
    in_valid = 4'b1000;
    in_last  = 4'b0000;
    #1;
    rst_n = 1'b0;
    #1;
    check("t5_out_valid", 32'(out_valid), 32'(0));
    check("t5_locked", 32'(locked), 32'(0));
    check("t5_in_ready", 32'(in_ready), 32'(0));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    cycle(4'b1111, 4'b1111, 1'b1, dacc);
    check("t5_init_order", 32'(dacc), 32'(4'b0001));
    repeat (2) cycle(4'b0000, 4'b0000, 1'b1, dacc);

    // 6: random traffic; requesters hold a beat until it is accepted
    verbose    = 0;
    chk_starve = 1;
    for (int i = 0; i < N; i++) wait_cnt[i] = 0;
    rv = '0;
    rl = '0;
    for (int c = 0; c < 10000; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!rv[i]) begin
          rv[i] = 1'($urandom_range(1, 0));
          rl[i] = ($urandom_range(2, 0) == 0);
        end
      end
      cycle(rv, rl, ($urandom_range(3, 0) != 0), dacc);
      rv = rv & ~dacc;
    end
    repeat (3) cycle(4'b0000, 4'b0000, 1'b1, dacc);
    check("sb_empty", 32'(sb_q.size()), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
